iic_cfg_seq: RTL and testbench
==============================

Name: iic_cfg_seq

Overview:
- Table-driven register-write sequencer for one I2C slave; the upstream command source that drives the shared iic_dri master (device_id/iic_trig/w_r/addr/data_in out, busy/byte_over/data_out in).
- Walks an external config ROM of (16-bit reg addr, 8-bit data) entries after a power-up delay, with inline delay entries, per-transaction timeout and bounded retry; asserts init_over when done.

Parameters:
- CLK_FRE, 27'd10_000_000, clk frequency in Hz; sets the 1 ms tick divider (CLK_FRE/1000 cycles).
- DEVICE_ID, 8'hB2, 8-bit I2C address byte presented on device_id.
- TBL_AW, 8, table index width.
- TBL_LEN, 8'd64, number of valid table entries (1..2^TBL_AW).
- POWERUP_MS, 16'd20, wait after reset/reinit before the first entry.
- TIMEOUT_CYC, 20'd100_000, maximum cycles from iic_trig to transaction done.
- MAX_RETRY, 3'd3, retries per entry before it is flagged and skipped.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- reinit  in  1  one-cycle pulse; restarts the sequence from the power-up wait
- tbl_idx  out  TBL_AW  ROM index
- tbl_addr  in  16  ROM register address, valid 1 cycle after tbl_idx changes; 16'hFFFF marks a delay entry
- tbl_data  in  8  ROM data, or delay in ms for delay entries
- device_id  out  8  constant DEVICE_ID
- iic_trig  out  1  one-cycle transaction start pulse
- w_r  out  1  1 = write, 0 = read
- addr  out  16  register address
- data_in  out  8  write data
- busy  in  1  master busy
- byte_over  in  1  one-cycle pulse per transferred byte
- data_out  in  8  read data, valid with byte_over
- init_over  out  1  sequence complete; held high
- cfg_err  out  1  sticky: at least one entry exhausted its retries
- err_cnt  out  8  count of skipped entries, saturates at 255

Behaviour:
- Reset values: tbl_idx=0, iic_trig=0, w_r=1, addr=0, data_in=0, init_over=0, cfg_err=0, err_cnt=0; state PWRUP; ms and cycle counters 0.
- ms tick: free-running divider, one-cycle pulse every CLK_FRE/1000 cycles; it is cleared on entry to PWRUP and DELAY.
- PWRUP: count POWERUP_MS ticks, then go to FETCH with tbl_idx=0.
- FETCH: wait 1 cycle for ROM latency, latch tbl_addr/tbl_data, then go to DECODE.
- DECODE: addr==16'hFFFF goes to DELAY (or NEXT if data==0). Otherwise go to TRIG and drive addr/data_in/w_r=1.
- DELAY: count tbl_data ms ticks, then go to NEXT.
- TRIG: wait until busy==0, then assert iic_trig for exactly 1 cycle, clear the cycle counter, and go to WAIT_BUSY.
- WAIT_BUSY: on busy==1, go to WAIT_DONE.
- WAIT_DONE: on a busy falling edge (busy==0 after being 1), the transaction is done; go to NEXT (or VERIFY, see option).
- Timeout: if the cycle counter reaches TIMEOUT_CYC in WAIT_BUSY or WAIT_DONE, this is a failed attempt.
- Failed attempt: retry counter +1; if retry counter <= MAX_RETRY, go back to TRIG. Otherwise set cfg_err=1, err_cnt+1 (saturating), and go to NEXT.
- NEXT: clear the retry counter. If tbl_idx==TBL_LEN-1, go to DONE; else tbl_idx+1, go to FETCH.
- DONE: init_over=1; iic_trig stays 0; outputs stay stable.
- reinit: in any state, next cycle returns to PWRUP. It clears init_over, tbl_idx, retry counter and cycle counter. cfg_err and err_cnt are cleared only by rst.
- reinit asserted mid-transaction: iic_trig is never reasserted until PWRUP completes. The in-flight master transaction is allowed to finish; TRIG's busy==0 guard protects against overlap.
- addr/data_in/w_r are held constant from TRIG until the transaction ends (done or timeout).
- A byte_over pulse outside WAIT_DONE is ignored.

Optional Feature:
- Macro: IIC_CFG_VERIFY_EN.
- Enabled: after each successful write, state VERIFY issues a read with the same guarded trigger rules: w_r=0, same addr, 1-cycle iic_trig.
  - data_out is captured on byte_over during the read.
  - On the busy falling edge, the captured byte is compared with data_in. A mismatch or timeout counts as a failed attempt and retries the write.
- Disabled: no read is ever issued; w_r is constantly 1; completion follows write done only.

Test Plan:
- Write path, no delays: CLK_FRE=10 MHz, POWERUP_MS=1, TBL_LEN=3, entries (0x0003,0x55),(0x1000,0xAA),(0x0016,0x01); model answers each trig with 40 cycles of busy.
  - Expect exactly 3 iic_trig pulses, the first no earlier than 10000 cycles after rst release.
  - Expect addr/data matching each entry, w_r=1, then init_over=1, cfg_err=0.
- Delay entry: table entries (0x0001,0x11),(0xFFFF,0x05),(0x0002,0x22).
  - Expect the gap between the 2nd trig and the preceding busy fall to be >= 50000 cycles; a delay entry with data 0x00 adds no wait.
- Timeout and retry: model never asserts busy for entry 1 of 2, TIMEOUT_CYC=1000, MAX_RETRY=3.
  - Expect 4 trigs on entry 1, then cfg_err=1, err_cnt=1, entry 2 still written, init_over=1.
- Reinit mid-sequence: pulse reinit while in WAIT_DONE of entry 5.
  - Expect init_over=0, no trig until a new POWERUP_MS elapses, then restart at tbl_idx=0; cfg_err preserved.
- Reset mid-operation: assert rst asynchronously during DELAY.
  - Expect all outputs at reset values the same cycle, then a full sequence restart after release.
- IIC_CFG_VERIFY_EN defined: model returns 0x54 for an expected 0x55 on the first read, then 0x55.
  - Expect the sequence write, read, write, read on that entry, then NEXT, and cfg_err=0.

Source files
------------

// File: rtl/iic_cfg_seq.sv
// iic_cfg_seq: table-driven I2C register-write sequencer feeding the shared iic_dri master.
// Walks a config ROM of {reg addr, data} entries after a power-up wait. Entries with
// addr 16'hFFFF are inline millisecond delays. Each write has a cycle timeout and
// bounded retry, and init_over is raised once the last entry is handled.
// Optional build macro IIC_CFG_VERIFY_EN: read back every write and retry on mismatch.
module iic_cfg_seq #(
    parameter logic [26:0]     CLK_FRE     = 27'd10_000_000,
    parameter logic [7:0]      DEVICE_ID   = 8'hB2,
    parameter int unsigned     TBL_AW      = 8,
    parameter logic [TBL_AW:0] TBL_LEN     = (TBL_AW + 1)'(64),
    parameter logic [15:0]     POWERUP_MS  = 16'd20,
    parameter logic [19:0]     TIMEOUT_CYC = 20'd100_000,
    parameter logic [2:0]      MAX_RETRY   = 3'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit,
    output logic [TBL_AW-1:0] tbl_idx,
    input  logic [15:0]       tbl_addr,
    input  logic [7:0]        tbl_data,
    output logic [7:0]        device_id,
    output logic              iic_trig,
    output logic              w_r,
    output logic [15:0]       addr,
    output logic [7:0]        data_in,
    input  logic              busy,
    input  logic              byte_over,
    input  logic [7:0]        data_out,
    output logic              init_over,
    output logic              cfg_err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned MS_DIV_RAW = 32'(CLK_FRE) / 1000;
    localparam int unsigned MS_DIV     = (MS_DIV_RAW > 1) ? MS_DIV_RAW : 1;
    localparam int unsigned DIV_W      = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [TBL_AW-1:0] LAST_IDX  = TBL_AW'(TBL_LEN - 1'b1);
    localparam logic [3:0]        RETRY_LIM = {1'b0, MAX_RETRY};
    localparam logic [15:0]       DELAY_TAG = 16'hFFFF;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_DELAY,
        S_TRIG,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_VERIFY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  ms_div;
    logic [15:0]       ms_cnt;
    logic [19:0]       cyc_cnt;
    logic [3:0]        retry_cnt;
    logic              fetch_wait;
    logic [15:0]       ent_addr;
    logic [7:0]        ent_data;

    logic              ms_tick_c;
    logic              done_c;
    logic              timeout_c;
    logic              fail_c;

`ifdef IIC_CFG_VERIFY_EN
    logic              rd_phase;
    logic [7:0]        rd_data;
    logic [7:0]        rd_byte_c;
`else
    // Read-back inputs are only consumed when verification is built in.
    logic              unused_in;
    assign unused_in = ^{byte_over, data_out};
`endif

    assign device_id = DEVICE_ID;

    // Millisecond tick, transaction completion and failed-attempt detection.
    always_comb begin
        ms_tick_c = (ms_div == DIV_W'(MS_DIV - 1));
        done_c    = (state == S_WAIT_DONE) && !busy;
        timeout_c = (((state == S_WAIT_BUSY) && !busy) || ((state == S_WAIT_DONE) && busy))
                    && (cyc_cnt >= TIMEOUT_CYC);
        fail_c    = timeout_c;
`ifdef IIC_CFG_VERIFY_EN
        rd_byte_c = byte_over ? data_out : rd_data;
        fail_c    = timeout_c || (done_c && rd_phase && (rd_byte_c != data_in));
`endif
    end

    // Sequencer FSM with registered bus-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_PWRUP;
            ms_div     <= '0;
            ms_cnt     <= '0;
            cyc_cnt    <= '0;
            retry_cnt  <= '0;
            fetch_wait <= 1'b0;
            ent_addr   <= '0;
            ent_data   <= '0;
            tbl_idx    <= '0;
            iic_trig   <= 1'b0;
            w_r        <= 1'b1;
            addr       <= '0;
            data_in    <= '0;
            init_over  <= 1'b0;
            cfg_err    <= 1'b0;
            err_cnt    <= '0;
`ifdef IIC_CFG_VERIFY_EN
            rd_phase   <= 1'b0;
            rd_data    <= '0;
`endif
        end else begin
            iic_trig <= 1'b0;
            ms_div   <= ms_tick_c ? '0 : ms_div + DIV_W'(1);

            if (reinit) begin
                // Restart from the power-up wait; error history is kept.
                state      <= S_PWRUP;
                ms_div     <= '0;
                ms_cnt     <= '0;
                cyc_cnt    <= '0;
                retry_cnt  <= '0;
                fetch_wait <= 1'b0;
                tbl_idx    <= '0;
                init_over  <= 1'b0;
`ifdef IIC_CFG_VERIFY_EN
                rd_phase   <= 1'b0;
`endif
            end else if (fail_c) begin
                // Failed attempt: re-issue the write or give up on this entry.
                w_r <= 1'b1;
`ifdef IIC_CFG_VERIFY_EN
                rd_phase <= 1'b0;
`endif
                if ((retry_cnt + 4'd1) <= RETRY_LIM) begin
                    retry_cnt <= retry_cnt + 4'd1;
                    state     <= S_TRIG;
                end else begin
                    cfg_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    state <= S_NEXT;
                end
            end else begin
                case (state)
                    S_PWRUP: begin
                        if (ms_cnt >= POWERUP_MS) begin
                            tbl_idx    <= '0;
                            fetch_wait <= 1'b0;
                            state      <= S_FETCH;
                        end else if (ms_tick_c) begin
                            ms_cnt <= ms_cnt + 16'd1;
                        end
                    end
                    S_FETCH: begin
                        // First cycle covers the ROM read latency.
                        if (!fetch_wait) begin
                            fetch_wait <= 1'b1;
                        end else begin
                            fetch_wait <= 1'b0;
                            ent_addr   <= tbl_addr;
                            ent_data   <= tbl_data;
                            state      <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        if (ent_addr == DELAY_TAG) begin
                            if (ent_data == 8'd0) begin
                                state <= S_NEXT;
                            end else begin
                                ms_div <= '0;
                                ms_cnt <= '0;
                                state  <= S_DELAY;
                            end
                        end else begin
                            addr    <= ent_addr;
                            data_in <= ent_data;
                            w_r     <= 1'b1;
                            state   <= S_TRIG;
                        end
                    end
                    S_DELAY: begin
                        if (ms_cnt >= {8'h00, ent_data}) begin
                            state <= S_NEXT;
                        end else if (ms_tick_c) begin
                            ms_cnt <= ms_cnt + 16'd1;
                        end
                    end
                    S_TRIG: begin
                        // Never start while the master is still finishing an older transfer.
                        if (!busy) begin
                            iic_trig <= 1'b1;
                            w_r      <= 1'b1;
                            cyc_cnt  <= '0;
                            state    <= S_WAIT_BUSY;
                        end
                    end
                    S_WAIT_BUSY: begin
                        cyc_cnt <= cyc_cnt + 20'd1;
                        if (busy) begin
                            state <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        cyc_cnt <= cyc_cnt + 20'd1;
`ifdef IIC_CFG_VERIFY_EN
                        if (byte_over) begin
                            rd_data <= data_out;
                        end
                        if (done_c) begin
                            if (rd_phase) begin
                                rd_phase <= 1'b0;
                                w_r      <= 1'b1;
                                state    <= S_NEXT;
                            end else begin
                                state <= S_VERIFY;
                            end
                        end
`else
                        if (done_c) begin
                            state <= S_NEXT;
                        end
`endif
                    end
`ifdef IIC_CFG_VERIFY_EN
                    S_VERIFY: begin
                        // Read back the register just written, same guard as a write.
                        if (!busy) begin
                            iic_trig <= 1'b1;
                            w_r      <= 1'b0;
                            rd_phase <= 1'b1;
                            cyc_cnt  <= '0;
                            state    <= S_WAIT_BUSY;
                        end
                    end
`endif
                    S_NEXT: begin
                        retry_cnt <= '0;
                        if (tbl_idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            tbl_idx    <= tbl_idx + TBL_AW'(1);
                            fetch_wait <= 1'b0;
                            state      <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        init_over <= 1'b1;
                    end
                    default: begin
                        state <= S_PWRUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: registered ROM model, simple I2C master responder,
// trigger logger, a table of sequence vectors and hand-written corner sequences.
module tb_iic_cfg_seq;

    localparam int unsigned MS_CYC = 100;
`ifdef IIC_CFG_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reinit = 1'b0;
    logic [2:0]  tbl_idx;
    logic [15:0] tbl_addr;
    logic [7:0]  tbl_data;
    logic [7:0]  device_id;
    logic        iic_trig;
    logic        w_r;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        busy;
    logic        byte_over;
    logic [7:0]  data_out;
    logic        init_over;
    logic        cfg_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    iic_cfg_seq #(
        .CLK_FRE    (27'd100_000),
        .DEVICE_ID  (8'hB2),
        .TBL_AW     (3),
        .TBL_LEN    (4'd8),
        .POWERUP_MS (16'd1),
        .TIMEOUT_CYC(20'd1000),
        .MAX_RETRY  (3'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .reinit   (reinit),
        .tbl_idx  (tbl_idx),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .device_id(device_id),
        .iic_trig (iic_trig),
        .w_r      (w_r),
        .addr     (addr),
        .data_in  (data_in),
        .busy     (busy),
        .byte_over(byte_over),
        .data_out (data_out),
        .init_over(init_over),
        .cfg_err  (cfg_err),
        .err_cnt  (err_cnt)
    );

    // Registered config ROM.
    logic [23:0] rom_mem [8];
    always @(posedge clk) {tbl_addr, tbl_data} <= rom_mem[tbl_idx];

    // Master responder: 40 busy cycles per accepted trigger, one byte_over inside.
    logic [15:0] dead_addr = 16'hBEEF;
    int          corrupt_reads = 0;
    int          reads_seen;
    int          bcnt;
    logic [7:0]  wr_last;
    logic [7:0]  rd_val;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            byte_over  <= 1'b0;
            data_out   <= 8'h00;
            bcnt       <= 0;
            reads_seen <= 0;
        end else begin
            byte_over <= 1'b0;
            if (bcnt != 0) begin
                bcnt <= bcnt - 1;
                if (bcnt == 1) busy <= 1'b0;
                if (bcnt == 10) begin
                    byte_over <= 1'b1;
                    data_out  <= rd_val;
                end
            end else if (iic_trig && addr != dead_addr) begin
                busy <= 1'b1;
                bcnt <= 40;
                if (w_r) begin
                    wr_last <= data_in;
                end else begin
                    reads_seen <= reads_seen + 1;
                    rd_val <= (reads_seen < corrupt_reads) ? (wr_last ^ 8'h01) : wr_last;
                end
            end
        end
    end

    // Trigger log, busy-fall timing, double-pulse and hold checks.
    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        int          gap;
    } trig_t;

    trig_t tlog[$];
    trig_t tnew;
    int    cyc;
    int    last_fall;
    int    dbl_cnt = 0;
    int    hold_viol = 0;
    logic  busy_q, trig_q, in_txn;
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; last_fall = 0; busy_q = 1'b0; trig_q = 1'b0; in_txn = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (iic_trig && trig_q) dbl_cnt = dbl_cnt + 1;
            if (iic_trig) begin
                tnew.cyc = cyc; tnew.a = addr; tnew.d = data_in; tnew.w = w_r;
                tnew.gap = cyc - last_fall;
                tlog.push_back(tnew);
            end
            if (busy && !busy_q) in_txn = 1'b1;
            if (!busy && busy_q) begin
                in_txn = 1'b0;
                last_fall = cyc;
            end
            if (in_txn && tlog.size() > 0 &&
                (addr != tlog[$].a || data_in != tlog[$].d || w_r != tlog[$].w))
                hold_viol = hold_viol + 1;
            busy_q = busy;
            trig_q = iic_trig;
        end
    end

    // Sequence vectors: ROM image plus expected writes and error outcome.
    typedef struct {
        logic [7:0][23:0] rom;
        logic [15:0]      dead;
        int               n_wr;
        int               n_rd;
        logic [5:0][23:0] exp_wr;
        logic             exp_err;
        logic [7:0]       exp_cnt;
    } vec_t;

    vec_t  vecs[3];
    trig_t wq[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    base, b_dbl, b_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int min);
        n_chk++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", nm, act, min);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        base = tlog.size();
        b_dbl = dbl_cnt;
        b_hold = hold_viol;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        release_rst();
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 8; i++) rom_mem[i] = v.rom[i];
        dead_addr = v.dead;
    endtask

    task automatic wait_init(input string nm, input int budget);
        int k = 0;
        while (!init_over && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " init_over reached"}, init_over, 1);
    endtask

    // Compare one completed run against its vector.
    task automatic check_vec(input vec_t v, input string nm);
        int nr = 0;
        wait_init(nm, 12000);
        wq.delete();
        for (int i = base; i < tlog.size(); i++) begin
            if (tlog[i].w) wq.push_back(tlog[i]);
            else nr++;
        end
        chk({nm, " write count"}, wq.size(), v.n_wr);
        chk({nm, " read count"}, nr, v.n_rd);
        for (int i = 0; i < v.n_wr && i < wq.size(); i++) begin
            chk($sformatf("%s wr%0d addr", nm, i), wq[i].a, v.exp_wr[i][23:8]);
            chk($sformatf("%s wr%0d data", nm, i), wq[i].d, v.exp_wr[i][7:0]);
        end
        chk_ge({nm, " first trig after powerup"}, (tlog.size() > base) ? tlog[base].cyc : 0, MS_CYC);
        chk({nm, " cfg_err"}, cfg_err, v.exp_err);
        chk({nm, " err_cnt"}, err_cnt, v.exp_cnt);
        chk({nm, " final tbl_idx"}, tbl_idx, 7);
        chk({nm, " iic_trig idle in DONE"}, iic_trig, 0);
        chk({nm, " single-cycle trig"}, dbl_cnt - b_dbl, 0);
        chk({nm, " bus fields held"}, hold_viol - b_hold, 0);
    endtask

    initial begin
        int r_cyc, n0, k;

        // Vector table.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) vecs[v].rom[i] = 24'hFFFF00;
            for (int i = 0; i < 6; i++) vecs[v].exp_wr[i] = 24'h0;
        end
        vecs[0].rom[0] = 24'h000355; vecs[0].rom[2] = 24'h1000AA; vecs[0].rom[3] = 24'h001601;
        vecs[0].dead = 16'hBEEF; vecs[0].n_wr = 3; vecs[0].n_rd = 3 * VFY;
        vecs[0].exp_wr[0] = 24'h000355; vecs[0].exp_wr[1] = 24'h1000AA; vecs[0].exp_wr[2] = 24'h001601;
        vecs[0].exp_err = 1'b0; vecs[0].exp_cnt = 8'd0;

        vecs[1].rom[0] = 24'h000111; vecs[1].rom[1] = 24'hFFFF05; vecs[1].rom[2] = 24'h000222;
        vecs[1].dead = 16'hBEEF; vecs[1].n_wr = 2; vecs[1].n_rd = 2 * VFY;
        vecs[1].exp_wr[0] = 24'h000111; vecs[1].exp_wr[1] = 24'h000222;
        vecs[1].exp_err = 1'b0; vecs[1].exp_cnt = 8'd0;

        vecs[2].rom[0] = 24'h000533; vecs[2].rom[1] = 24'h000644;
        vecs[2].dead = 16'h0005; vecs[2].n_wr = 5; vecs[2].n_rd = 1 * VFY;
        for (int i = 0; i < 4; i++) vecs[2].exp_wr[i] = 24'h000533;
        vecs[2].exp_wr[4] = 24'h000644;
        vecs[2].exp_err = 1'b1; vecs[2].exp_cnt = 8'd1;

        // Reset state.
        load_vec(vecs[0]);
        repeat (2) @(negedge clk);
        chk("rst tbl_idx", tbl_idx, 0);
        chk("rst iic_trig", iic_trig, 0);
        chk("rst w_r", w_r, 1);
        chk("rst addr", addr, 0);
        chk("rst data_in", data_in, 0);
        chk("rst init_over", init_over, 0);
        chk("rst cfg_err", cfg_err, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("device_id", device_id, 8'hB2);

        // Table-driven sequences.
        for (int v = 0; v < 3; v++) begin
            load_vec(vecs[v]);
            apply_reset();
            check_vec(vecs[v], $sformatf("vec%0d", v));
            if (v == 0) chk("zero delay adds no wait", (wq.size() > 1 && wq[1].gap < 20) ? 1 : 0, 1);
            if (v == 1) chk_ge("delay entry gap", (wq.size() > 1) ? wq[1].gap : 0, 5 * MS_CYC);
        end

        // Reinit while entry 5 is in flight.
        rom_mem[0] = 24'h000533; rom_mem[1] = 24'h001101; rom_mem[2] = 24'h001202;
        rom_mem[3] = 24'h001303; rom_mem[4] = 24'h001404; rom_mem[5] = 24'h001505;
        rom_mem[6] = 24'hFFFF00; rom_mem[7] = 24'hFFFF00;
        dead_addr = 16'h0005;
        apply_reset();
        k = 0;
        while (!(tbl_idx == 3'd5 && busy) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("reinit reached entry 5", (tbl_idx == 3'd5 && busy) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        r_cyc = cyc;
        chk("reinit init_over", init_over, 0);
        chk("reinit tbl_idx", tbl_idx, 0);
        chk("reinit cfg_err kept", cfg_err, 1);
        chk("reinit err_cnt kept", err_cnt, 1);
        n0 = tlog.size();
        k = 0;
        while (tlog.size() == n0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk_ge("reinit trig after powerup", (tlog.size() > n0) ? tlog[n0].cyc - r_cyc : 0, MS_CYC);
        chk("reinit restart addr", (tlog.size() > n0) ? tlog[n0].a : 16'h0, 16'h0005);
        wait_init("reinit", 20000);
        chk("reinit err_cnt after rerun", err_cnt, 2);
        chk("reinit cfg_err after rerun", cfg_err, 1);
        chk("reinit single-cycle trig", dbl_cnt - b_dbl, 0);

        // Asynchronous reset during a delay entry.
        load_vec(vecs[1]);
        apply_reset();
        k = 0;
        while (tbl_idx != 3'd1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (50) @(negedge clk);
        chk("pre-rst addr loaded", addr, 16'h0001);
        #2 rst = 1'b1;
        #1;
        chk("async rst tbl_idx", tbl_idx, 0);
        chk("async rst iic_trig", iic_trig, 0);
        chk("async rst w_r", w_r, 1);
        chk("async rst addr", addr, 0);
        chk("async rst data_in", data_in, 0);
        chk("async rst init_over", init_over, 0);
        chk("async rst err_cnt", err_cnt, 0);
        repeat (2) @(negedge clk);
        release_rst();
        check_vec(vecs[1], "rst-restart");

`ifdef IIC_CFG_VERIFY_EN
        // Read-back returns a wrong byte once: write, read, write, read.
        for (int i = 0; i < 8; i++) rom_mem[i] = 24'hFFFF00;
        rom_mem[0] = 24'h000355;
        dead_addr = 16'hBEEF;
        corrupt_reads = 1;
        apply_reset();
        wait_init("verify", 12000);
        chk("verify trig count", tlog.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("verify trig%0d w_r", i), (tlog.size() > base + i) ? tlog[base + i].w : 1'bx, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("verify trig%0d addr", i), (tlog.size() > base + i) ? tlog[base + i].a : 16'h0, 16'h0003);
        end
        chk("verify cfg_err", cfg_err, 0);
        corrupt_reads = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

endmodule
